// File: rtl/imem_fetch.sv
// rtl/imem_fetch.sv - synchronous-read instruction memory with NOP clear sweep, load port and stall-hold fetch
// Optional IMEM_BYPASS_EN: same-cycle load data is forwarded to a fetch of the same index.
module imem_fetch #(
  parameter int                 DATA_W    = 32,
  parameter int                 ADDR_W    = 32,
  parameter int                 DEPTH     = 64,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = 100,
  parameter logic [DATA_W-1:0]  NOP_WORD  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic              stall,
  output logic              fetch_ready,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  output logic              addr_fault,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              clr_busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  clr_cnt;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] fetch_off, ld_off;
  logic              fetch_ok, ld_ok;
  logic [IDX_W-1:0]  fetch_idx, ld_idx;
  logic              accept, ld_hit;
  logic [DATA_W-1:0] rd_word;

  // The >= compare guards the subtraction, so a PC below the window never wraps into range.
  assign fetch_off = fetch_pc - BASE_ADDR;
  assign ld_off    = ld_addr - BASE_ADDR;
  assign fetch_ok  = (fetch_pc >= BASE_ADDR) && (fetch_off[1:0] == 2'b00) &&
                     ((fetch_off >> 2) < ADDR_W'(DEPTH));
  assign ld_ok     = (ld_addr >= BASE_ADDR) && (ld_off[1:0] == 2'b00) &&
                     ((ld_off >> 2) < ADDR_W'(DEPTH));
  assign fetch_idx = fetch_off[IDX_W+1:2];
  assign ld_idx    = ld_off[IDX_W+1:2];

  always_comb begin
    state_nxt   = state;
    clr_busy    = 1'b0;
    fetch_ready = 1'b0;
    case (state)
      S_CLEAR: begin
        clr_busy = 1'b1;
        if (clr_cnt == IDX_W'(DEPTH - 1)) state_nxt = S_RUN;
      end
      S_RUN: begin
        fetch_ready = !(instr_valid && stall);
      end
      default: state_nxt = S_CLEAR;
    endcase
  end

  assign accept = fetch_req && fetch_ready;
  assign ld_hit = (state == S_RUN) && ld_en && ld_ok;

  always_comb begin
    rd_word = mem[fetch_idx];
`ifdef IMEM_BYPASS_EN
    if (ld_hit && (ld_idx == fetch_idx)) rd_word = ld_data;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_CLEAR;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst)                   clr_cnt <= '0;
    else if (state == S_CLEAR) clr_cnt <= clr_cnt + 1'b1;
  end

  // Memory has no reset of its own; the sweep overwrites every entry instead.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_CLEAR) mem[clr_cnt] <= NOP_WORD;
      else if (ld_hit)      mem[ld_idx]  <= ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_valid <= 1'b0;
      addr_fault  <= 1'b0;
      instr_out   <= NOP_WORD;
    end else if (accept) begin
      instr_valid <= 1'b1;
      addr_fault  <= !fetch_ok;
      instr_out   <= fetch_ok ? rd_word : NOP_WORD;
    end else if (!(instr_valid && stall)) begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_imem_fetch.sv
// tb/tb_imem_fetch.sv - randomized and directed self-checking bench for imem_fetch against a behavioural model
module tb_imem_fetch;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'd100;
  localparam logic [31:0] NOP   = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_pc;
  logic        stall;
  logic        fetch_ready;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic        addr_fault;
  logic        ld_en;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        clr_busy;

  int errors = 0;
  int checks = 0;

  imem_fetch dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_pc(fetch_pc), .stall(stall),
    .fetch_ready(fetch_ready), .instr_out(instr_out), .instr_valid(instr_valid),
    .addr_fault(addr_fault), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .clr_busy(clr_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: memory as a plain word array, sweep tracked as edges since reset.
  logic [31:0] m_mem [DEPTH];
  int          m_edges = 0;
  bit          m_init = 0;
  bit          m_valid = 0;
  bit          m_fault = 0;
  logic [31:0] m_out = '0;
  bit          m_hold;
  logic [31:0] m_rd;

  function automatic bit in_win(input logic [31:0] a);
    if (a < BASE) return 0;
    return ((a - BASE) % 4 == 0) && ((a - BASE) / 4 < DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) / 4);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_init  = 1;
      m_edges = 0;
      m_valid = 0;
      m_fault = 0;
      m_out   = NOP;
      for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
    end else if (m_init) begin
      if (m_edges >= DEPTH) begin
        m_hold = m_valid && stall;
        if (!m_hold && fetch_req) begin
          m_rd = in_win(fetch_pc) ? m_mem[widx(fetch_pc)] : NOP;
`ifdef IMEM_BYPASS_EN
          if (in_win(fetch_pc) && ld_en && in_win(ld_addr) && widx(ld_addr) == widx(fetch_pc))
            m_rd = ld_data;
`endif
          m_valid = 1;
          m_fault = !in_win(fetch_pc);
          m_out   = m_rd;
        end else if (!m_hold) begin
          m_valid = 0;
        end
        if (ld_en && in_win(ld_addr)) m_mem[widx(ld_addr)] = ld_data;
      end
      if (m_edges < 100000) m_edges++;
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("clr_busy", 32'(clr_busy), 32'(m_edges < DEPTH));
      chk("fetch_ready", 32'(fetch_ready), 32'((m_edges >= DEPTH) && !(m_valid && stall)));
      chk("instr_valid", 32'(instr_valid), 32'(m_valid));
      if (m_valid) begin
        chk("instr_out", instr_out, m_out);
        chk("addr_fault", 32'(addr_fault), 32'(m_fault));
      end
    end
  end

  task automatic cyc(input logic r, input logic rq, input logic [31:0] pc, input logic st,
                     input logic le, input logic [31:0] la, input logic [31:0] ld);
    rst = r; fetch_req = rq; fetch_pc = pc; stall = st;
    ld_en = le; ld_addr = la; ld_data = ld;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic fetch(input logic [31:0] pc);
    cyc(0, 1, pc, 0, 0, 0, 0);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    cyc(0, 0, 0, 0, 1, a, d);
  endtask

  task automatic wait_clear();
    int n;
    n = 0;
    rst = 0; fetch_req = 0; ld_en = 0; stall = 0;
    while (clr_busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("sweep_len", n, DEPTH);
  endtask

  initial begin
    logic [31:0] exp_col;
    rst = 1; fetch_req = 0; fetch_pc = 0; stall = 0; ld_en = 0; ld_addr = 0; ld_data = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_fault", 32'(addr_fault), 0);
    chk("rst_out", instr_out, NOP);
    chk("rst_ready", 32'(fetch_ready), 0);
    chk("rst_busy", 32'(clr_busy), 1);

    wait_clear();
    chk("ready_after_sweep", 32'(fetch_ready), 1);
    for (int i = 0; i < DEPTH; i++) begin
      fetch(BASE + 32'(4 * i));
      chk("cleared_entry", instr_out, 32'h0);
    end

    // Mid-sweep reset restarts the full sweep.
    rst = 1; @(posedge clk); #1;
    rst = 0;
    repeat (20) idle();
    cyc(1, 0, 0, 0, 0, 0, 0);
    wait_clear();

    load(100, 32'h00221820);
    load(104, 32'h01232022);
    load(108, 32'h00692825);
    fetch(100); chk("ld_fetch100", instr_out, 32'h00221820);
    fetch(104); chk("ld_fetch104", instr_out, 32'h01232022);
    chk("ld_valid", 32'(instr_valid), 1);
    fetch(108); chk("ld_fetch108", instr_out, 32'h00692825);
    chk("ld_fault", 32'(addr_fault), 0);

    fetch(96);  chk("fault96", 32'(addr_fault), 1);  chk("fault96_out", instr_out, NOP);
    fetch(102); chk("fault102", 32'(addr_fault), 1); chk("fault102_out", instr_out, NOP);
    fetch(356); chk("fault356", 32'(addr_fault), 1); chk("fault356_valid", 32'(instr_valid), 1);
    load(356, 32'hDEADBEEF);
    fetch(100); chk("after_bad_load", instr_out, 32'h00221820);

    fetch(104); chk("stall_first", instr_out, 32'h01232022);
    for (int i = 0; i < 3; i++) begin
      rst = 0; fetch_req = 1; fetch_pc = 108; stall = 1; ld_en = 0;
      #1;
      chk("stall_ready", 32'(fetch_ready), 0);
      @(posedge clk); #1;
      chk("stall_hold", instr_out, 32'h01232022);
    end
    fetch(108); chk("stall_release", instr_out, 32'h00692825);

    load(112, 32'hAAAAAAAA);
`ifdef IMEM_BYPASS_EN
    exp_col = 32'h00693026;
`else
    exp_col = 32'hAAAAAAAA;
`endif
    cyc(0, 1, 112, 0, 1, 112, 32'h00693026);
    chk("collision", instr_out, exp_col);
    fetch(112); chk("refetch112", instr_out, 32'h00693026);

    // Reset with a fetch in flight discards it and wipes loaded words.
    fetch(100);
    cyc(1, 1, 104, 0, 0, 0, 0);
    chk("rst_inflight_valid", 32'(instr_valid), 0);
    wait_clear();
    fetch(100); chk("wiped100", instr_out, 32'h0);
    fetch(104); chk("wiped104", instr_out, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc, la;
      pc = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(80, 400))
                                       : BASE + 32'(4 * $urandom_range(0, 68));
      la = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(80, 400))
                                       : BASE + 32'(4 * $urandom_range(0, 68));
      cyc(($urandom_range(0, 799) == 0), ($urandom_range(0, 3) != 0), pc,
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0), la, $urandom);
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
